// File: rtl/regfile_dump_if.sv
// regfile_dump_if: control, register-file read port and beat stream of the snapshot reader
interface regfile_dump_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
);
    logic              start;
    logic              busy;
    logic              done;
    logic              stall_req;
    logic              stall_ack;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_idx;
    logic [DATA_W-1:0] out_data;
    modport master (
        output start, stall_ack, rd_data, out_ready,
        input  busy, done, stall_req, rd_idx, out_valid, out_idx, out_data
    );
    modport slave (
        input  start, stall_ack, rd_data, out_ready,
        output busy, done, stall_req, rd_idx, out_valid, out_idx, out_data
    );
endinterface

// File: rtl/regfile_dump.sv
// regfile_dump: stalls the core, then streams registers FIRST_IDX..LAST_IDX
// as idx/data beats over valid/ready while the stall is held.
module regfile_dump #(
    parameter int DATA_W    = 32,
    parameter int IDX_W     = 5,
    parameter int FIRST_IDX = 0,
    parameter int LAST_IDX  = 31
) (
    input logic           clk,
    input logic           rst,
    regfile_dump_if.slave bus
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] READ = 3'd2;
    localparam logic [2:0] SEND = 3'd3;
    localparam logic [2:0] DONE = 3'd4;
    logic [2:0]        state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        out_idx_d  = out_idx_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = REQ;
                cnt_d   = IDX_W'(FIRST_IDX);
            end
            REQ: state_d = bus.stall_ack ? READ : REQ;
            // losing the ack here means the read port may not be ours: retry
            READ: if (bus.stall_ack) begin
                out_idx_d  = cnt_q;
                out_data_d = bus.rd_data;
                state_d    = SEND;
            end else begin
                state_d = REQ;
            end
            SEND: if (bus.out_ready) begin
                if (cnt_q == IDX_W'(LAST_IDX)) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + IDX_W'(1);
                    state_d = READ;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= IDX_W'(FIRST_IDX);
            out_idx_q  <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_idx_q  <= out_idx_d;
            out_data_q <= out_data_d;
        end
    end
    assign bus.busy      = state_q != IDLE;
    assign bus.done      = state_q == DONE;
    assign bus.stall_req = state_q == REQ || state_q == READ || state_q == SEND;
    assign bus.out_valid = state_q == SEND;
    assign bus.rd_idx    = cnt_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: randomized scenarios against a register-array model of the
// expected snapshot stream (every index once, in order, with its register value).
module tb_regfile_dump;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_dump_if #(.DATA_W(32), .IDX_W(5)) ifa ();
    regfile_dump_if #(.DATA_W(32), .IDX_W(5)) ifb ();

    regfile_dump #(.DATA_W(32), .IDX_W(5), .FIRST_IDX(0), .LAST_IDX(31))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    regfile_dump #(.DATA_W(32), .IDX_W(5), .FIRST_IDX(3), .LAST_IDX(3))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    logic [31:0] regs [32];
    // without the stall the read port belongs to the core: hand back junk
    assign ifa.rd_data = ifa.stall_ack ? regs[ifa.rd_idx] : 32'hBAD0_BAD0;
    assign ifb.rd_data = ifb.stall_ack ? regs[ifb.rd_idx] : 32'hBAD0_BAD0;

    typedef struct packed { logic [4:0] idx; logic [31:0] data; } beat_t;
    beat_t qa[$], qb[$];
    int cyc = 0, done_a = 0, done_b = 0, done_cyc_a = 0, done_cyc_b = 0, first_a = -1;
    int compared = 0, mismatched = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (ifa.out_valid && ifa.out_ready) qa.push_back({ifa.out_idx, ifa.out_data});
        if (ifa.out_valid && first_a < 0) first_a = cyc;
        if (ifa.done) begin done_a++; done_cyc_a = cyc; end
        if (ifb.out_valid && ifb.out_ready) qb.push_back({ifb.out_idx, ifb.out_data});
        if (ifb.done) begin done_b++; done_cyc_b = cyc; end
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_a();
        qa.delete(); done_a = 0; first_a = -1;
    endtask

    task automatic pulse_a();
        ifa.start = 1'b1; step(); ifa.start = 1'b0;
    endtask

    task automatic fill_random();
        regs[0] = '0;
        for (int i = 1; i < 32; i++) regs[i] = $urandom;
    endtask

    task automatic fill_linear();
        for (int i = 0; i < 32; i++) regs[i] = 32'(4 * i);
    endtask

    task automatic wait_done_a(input int budget);
        int d0 = done_a;
        int n = 0;
        while (done_a == d0 && n < budget) begin step(); n++; end
        compared++;
        if (done_a == d0) begin
            mismatched++;
            $display("FAIL done_timeout: no done within %0d cycles (required a done pulse)", budget);
        end
    endtask

    task automatic wait_beat_a(input int idx);
        int n = 0;
        while (!(ifa.out_valid && ifa.out_idx == 5'(idx)) && n < 300) begin step(); n++; end
        compared++;
        if (n >= 300) begin
            mismatched++;
            $display("FAIL beat_timeout: beat idx %0d never offered", idx);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifa.start = 0; ifa.stall_ack = 0; ifa.out_ready = 0;
        ifb.start = 0; ifb.stall_ack = 0; ifb.out_ready = 0;
        fill_linear();
        step(3);
        compared++;
        if ({ifa.busy, ifa.done, ifa.stall_req, ifa.out_valid} !== 4'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl_a: busy/done/stall/valid=%b required 0000",
                     {ifa.busy, ifa.done, ifa.stall_req, ifa.out_valid});
        end
        compared++;
        if (ifa.out_idx !== 5'd0 || ifa.out_data !== 32'd0 || ifa.rd_idx !== 5'd0) begin
            mismatched++;
            $display("FAIL reset_data_a: out_idx=%0d out_data=%h rd_idx=%0d required 0/0/0",
                     ifa.out_idx, ifa.out_data, ifa.rd_idx);
        end
        compared++;
        if (ifb.busy !== 1'b0 || ifb.stall_req !== 1'b0 || ifb.rd_idx !== 5'd3) begin
            mismatched++;
            $display("FAIL reset_b: busy=%b stall_req=%b rd_idx=%0d required 0/0/3",
                     ifb.busy, ifb.stall_req, ifb.rd_idx);
        end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_basic();
        int e0;
        for (int i = 0; i < 32; i++) regs[i] = 32'(4 * i);
        regs[1] = 32'hDEAD_BEEF; regs[31] = 32'h1234_5678;
        clear_a();
        ifa.stall_ack = 1; ifa.out_ready = 1;
        pulse_a();
        e0 = cyc;
        wait_done_a(200);
        step(3);
        compared++;
        if (qa.size() !== 32) begin
            mismatched++;
            $display("FAIL basic_count: %0d beats required 32", qa.size());
        end
        for (int i = 0; i < qa.size() && i < 32; i++) begin
            compared++;
            if (qa[i] !== {5'(i), regs[i]}) begin
                mismatched++;
                $display("FAIL basic_beat%0d: got idx %0d data %h required idx %0d data %h",
                         i, qa[i].idx, qa[i].data, i, regs[i]);
            end
        end
        if (qa.size() == 32) begin
            compared++;
            if (qa[0].data !== 32'd0 || qa[1].data !== 32'hDEAD_BEEF ||
                qa[5].data !== 32'h14 || qa[31].data !== 32'h1234_5678) begin
                mismatched++;
                $display("FAIL basic_known: x0=%h x1=%h x5=%h x31=%h required 0/deadbeef/14/12345678",
                         qa[0].data, qa[1].data, qa[5].data, qa[31].data);
            end
        end
        compared++;
        if (done_a !== 1 || done_cyc_a - e0 !== 65) begin
            mismatched++;
            $display("FAIL basic_done: %0d pulses after edge %0d required 1 after edge 65",
                     done_a, done_cyc_a - e0);
        end
        compared++;
        if (first_a - e0 !== 2) begin
            mismatched++;
            $display("FAIL basic_first_valid: after edge %0d required 2", first_a - e0);
        end
        compared++;
        if (ifa.busy !== 0 || ifa.stall_req !== 0 || ifa.out_valid !== 0 ||
            ifa.out_idx !== 5'd31 || ifa.out_data !== 32'h1234_5678) begin
            mismatched++;
            $display("FAIL basic_after: busy=%b stall=%b valid=%b idx=%0d data=%h required 0/0/0/31/12345678",
                     ifa.busy, ifa.stall_req, ifa.out_valid, ifa.out_idx, ifa.out_data);
        end
    endtask

    task automatic test_backpressure();
        fill_linear();
        clear_a();
        ifa.stall_ack = 1; ifa.out_ready = 1;
        pulse_a();
        wait_beat_a(7);
        ifa.out_ready = 0;
        for (int k = 0; k < 5; k++) begin
            compared++;
            if (ifa.out_valid !== 1 || ifa.out_idx !== 5'd7 || ifa.out_data !== 32'h1C) begin
                mismatched++;
                $display("FAIL bp_hold%0d: valid=%b idx=%0d data=%h required 1/7/0000001c",
                         k, ifa.out_valid, ifa.out_idx, ifa.out_data);
            end
            step();
        end
        ifa.out_ready = 1;
        wait_done_a(200);
        step(2);
        compared++;
        if (qa.size() !== 32) begin
            mismatched++;
            $display("FAIL bp_count: %0d beats required 32", qa.size());
        end
        for (int i = 0; i < qa.size() && i < 32; i++) begin
            compared++;
            if (qa[i] !== {5'(i), regs[i]}) begin
                mismatched++;
                $display("FAIL bp_beat%0d: got idx %0d data %h required idx %0d data %h",
                         i, qa[i].idx, qa[i].data, i, regs[i]);
            end
        end
    endtask

    task automatic test_late_ack();
        fill_random();
        clear_a();
        ifa.stall_ack = 0; ifa.out_ready = 1;
        pulse_a();
        for (int k = 0; k < 10; k++) begin
            compared++;
            if (ifa.stall_req !== 1 || ifa.out_valid !== 0) begin
                mismatched++;
                $display("FAIL late_wait%0d: stall_req=%b valid=%b required 1/0",
                         k, ifa.stall_req, ifa.out_valid);
            end
            step();
        end
        ifa.stall_ack = 1;
        step();
        compared++;
        if (ifa.out_valid !== 0) begin
            mismatched++;
            $display("FAIL late_early: valid=%b one edge after ack required 0", ifa.out_valid);
        end
        step();
        compared++;
        if (ifa.out_valid !== 1 || ifa.out_idx !== 5'd0 || ifa.out_data !== regs[0]) begin
            mismatched++;
            $display("FAIL late_first: valid=%b idx=%0d data=%h required 1/0/%h",
                     ifa.out_valid, ifa.out_idx, ifa.out_data, regs[0]);
        end
        wait_done_a(200);
        step(2);
        compared++;
        if (qa.size() !== 32 || done_a !== 1) begin
            mismatched++;
            $display("FAIL late_count: %0d beats %0d dones required 32/1", qa.size(), done_a);
        end
    endtask

    task automatic test_ack_drop();
        int n = 0;
        fill_random();
        clear_a();
        ifa.stall_ack = 1; ifa.out_ready = 1;
        pulse_a();
        while (!(ifa.rd_idx == 5'd12 && ifa.busy && !ifa.out_valid) && n < 300) begin step(); n++; end
        ifa.stall_ack = 0;
        step();
        ifa.stall_ack = 1;
        compared++;
        if (ifa.stall_req !== 1 || ifa.out_valid !== 0 || ifa.rd_idx !== 5'd12) begin
            mismatched++;
            $display("FAIL drop_req: stall=%b valid=%b rd_idx=%0d required 1/0/12",
                     ifa.stall_req, ifa.out_valid, ifa.rd_idx);
        end
        step(2);
        compared++;
        if (ifa.out_valid !== 1 || ifa.out_idx !== 5'd12 || ifa.out_data !== regs[12]) begin
            mismatched++;
            $display("FAIL drop_beat: valid=%b idx=%0d data=%h required 1/12/%h",
                     ifa.out_valid, ifa.out_idx, ifa.out_data, regs[12]);
        end
        wait_done_a(200);
        step(2);
        compared++;
        if (qa.size() !== 32) begin
            mismatched++;
            $display("FAIL drop_count: %0d beats required 32", qa.size());
        end
        for (int i = 0; i < qa.size() && i < 32; i++) begin
            compared++;
            if (qa[i] !== {5'(i), regs[i]}) begin
                mismatched++;
                $display("FAIL drop_beat%0d: got idx %0d data %h required idx %0d data %h",
                         i, qa[i].idx, qa[i].data, i, regs[i]);
            end
        end
    endtask

    task automatic test_restart_ignored();
        int n;
        fill_random();
        clear_a();
        ifa.stall_ack = 0; ifa.out_ready = 1;
        pulse_a();
        step(2);
        pulse_a();
        ifa.stall_ack = 1;
        repeat (4) begin
            n = 0;
            while (!ifa.out_valid && n < 50) begin step(); n++; end
            pulse_a();
            step(2);
        end
        wait_done_a(200);
        step(6);
        compared++;
        if (qa.size() !== 32 || done_a !== 1 || ifa.busy !== 0) begin
            mismatched++;
            $display("FAIL restart: %0d beats %0d dones busy=%b required 32/1/0",
                     qa.size(), done_a, ifa.busy);
        end
        for (int i = 0; i < qa.size() && i < 32; i++) begin
            compared++;
            if (qa[i] !== {5'(i), regs[i]}) begin
                mismatched++;
                $display("FAIL restart_beat%0d: got idx %0d data %h required idx %0d data %h",
                         i, qa[i].idx, qa[i].data, i, regs[i]);
            end
        end
    endtask

    task automatic test_random();
        int n = 0;
        logic hold = 0;
        beat_t held = '0;
        fill_random();
        clear_a();
        ifa.stall_ack = 0; ifa.out_ready = 0;
        pulse_a();
        while (done_a == 0 && n < 3000) begin
            if (hold) begin
                compared++;
                if (ifa.out_valid !== 1 || {ifa.out_idx, ifa.out_data} !== held) begin
                    mismatched++;
                    $display("FAIL rand_stable: valid=%b idx=%0d data=%h required 1/%0d/%h",
                             ifa.out_valid, ifa.out_idx, ifa.out_data, held.idx, held.data);
                end
            end
            ifa.stall_ack = $urandom_range(0, 3) != 0;
            ifa.out_ready = $urandom_range(0, 1) == 1;
            ifa.start = ifa.busy && $urandom_range(0, 4) == 0;
            hold = ifa.out_valid && !ifa.out_ready;
            held = {ifa.out_idx, ifa.out_data};
            step();
            n++;
        end
        ifa.start = 0;
        step(4);
        compared++;
        if (qa.size() !== 32 || done_a !== 1) begin
            mismatched++;
            $display("FAIL rand_count: %0d beats %0d dones required 32/1", qa.size(), done_a);
        end
        for (int i = 0; i < qa.size() && i < 32; i++) begin
            compared++;
            if (qa[i] !== {5'(i), regs[i]}) begin
                mismatched++;
                $display("FAIL rand_beat%0d: got idx %0d data %h required idx %0d data %h",
                         i, qa[i].idx, qa[i].data, i, regs[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        fill_linear();
        clear_a();
        ifa.stall_ack = 1; ifa.out_ready = 1;
        pulse_a();
        wait_beat_a(12);
        rst = 1'b1;
        #1;
        compared++;
        if ({ifa.stall_req, ifa.out_valid, ifa.busy} !== 3'b0 ||
            ifa.out_idx !== 5'd0 || ifa.out_data !== 32'd0) begin
            mismatched++;
            $display("FAIL rstmid: stall/valid/busy=%b idx=%0d data=%h required 000/0/0",
                     {ifa.stall_req, ifa.out_valid, ifa.busy}, ifa.out_idx, ifa.out_data);
        end
        step();
        rst = 1'b0;
        step(2);
        clear_a();
        pulse_a();
        wait_done_a(200);
        step(2);
        compared++;
        if (qa.size() !== 32 || done_a !== 1) begin
            mismatched++;
            $display("FAIL rstmid_count: %0d beats %0d dones required 32/1", qa.size(), done_a);
        end
        for (int i = 0; i < qa.size() && i < 32; i++) begin
            compared++;
            if (qa[i] !== {5'(i), regs[i]}) begin
                mismatched++;
                $display("FAIL rstmid_beat%0d: got idx %0d data %h required idx %0d data %h",
                         i, qa[i].idx, qa[i].data, i, regs[i]);
            end
        end
    endtask

    task automatic test_single();
        int e0;
        int n = 0;
        fill_random();
        qb.delete(); done_b = 0;
        ifb.stall_ack = 1; ifb.out_ready = 1;
        ifb.start = 1; step(); ifb.start = 0;
        e0 = cyc;
        while (done_b == 0 && n < 100) begin step(); n++; end
        step(2);
        compared++;
        if (qb.size() !== 1) begin
            mismatched++;
            $display("FAIL single_count: %0d beats required 1", qb.size());
        end
        if (qb.size() > 0) begin
            compared++;
            if (qb[0] !== {5'd3, regs[3]}) begin
                mismatched++;
                $display("FAIL single_beat: idx %0d data %h required idx 3 data %h",
                         qb[0].idx, qb[0].data, regs[3]);
            end
        end
        compared++;
        if (done_b !== 1 || done_cyc_b - e0 !== 3) begin
            mismatched++;
            $display("FAIL single_done: %0d pulses after edge %0d required 1 after edge 3",
                     done_b, done_cyc_b - e0);
        end
        compared++;
        if (ifb.busy !== 0 || ifb.out_idx !== 5'd3 || ifb.rd_idx !== 5'd3) begin
            mismatched++;
            $display("FAIL single_after: busy=%b out_idx=%0d rd_idx=%0d required 0/3/3",
                     ifb.busy, ifb.out_idx, ifb.rd_idx);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_late_ack();
        test_ack_drop();
        test_restart_ignored();
        repeat (2) test_random();
        test_reset_mid();
        test_single();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
